// File: rtl/tempsense_pkg.sv
// Shared types and widths for the temperature-sensor readout.
// Optional averaging is selected by TEMPSENSE_AVG_EN.
package tempsense_pkg;

    localparam int ADC_W    = 12;
    localparam int AVG_LOG2 = 3;
    localparam int ACC_W    = ADC_W + AVG_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DISCARD,
        ST_ACQ,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/tempsense_avg.sv
// Sample accumulator and counter; TEMPSENSE_AVG_EN selects 8-sample mean,
// otherwise the single accepted sample passes straight through.
module tempsense_avg
    import tempsense_pkg::*;
(
`ifdef TEMPSENSE_AVG_EN
    input  logic             clk_i,
    input  logic             rst_n_i,
`endif
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [ADC_W-1:0] data_i,
    output logic             last_o,
    output logic [ADC_W-1:0] mean_o
);

`ifdef TEMPSENSE_AVG_EN
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;

    always_comb begin
        sum   = acc_q + ACC_W'(data_i);
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            acc_d = sum;
            cnt_d = cnt_q + AVG_LOG2'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // mean includes the sample being accepted this cycle
    assign last_o = add_i & ~clr_i & (&cnt_q);
    assign mean_o = sum[ACC_W-1:AVG_LOG2];
`else
    assign last_o = add_i & ~clr_i;
    assign mean_o = data_i;
`endif

endmodule

// File: rtl/tempsense_readout.sv
// Temperature-sensor readout sequencer: settle, discard, acquire, hold.
// Define TEMPSENSE_AVG_EN to average 8 samples per window.
module tempsense_readout
    import tempsense_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 64,
    parameter int DISCARD_SAMPLES = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic             HF_CLK,
    input  logic             NRST_sync,
    input  logic             temp_run,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             DONE,
    output logic [ADC_W-1:0] TEMP_DATA,
    output logic             TEMP_ERR
);

    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    localparam int DW = $clog2(DISCARD_SAMPLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [SW-1:0] SETTLE_LAST =
        SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [DW-1:0] DISC_LAST =
        DW'((DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // zero-length phases are skipped entirely
    localparam state_e POST_SETTLE =
        (DISCARD_SAMPLES > 0) ? ST_DISCARD : ST_ACQ;
    localparam state_e RUN_ENTRY =
        (SETTLE_CYCLES > 0) ? ST_SETTLE : POST_SETTLE;

    state_e          state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [DW-1:0]   disc_q, disc_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [ADC_W-1:0] data_q, data_d;

    logic             avg_clr;
    logic             avg_add;
    logic             avg_last;
    logic [ADC_W-1:0] avg_mean;

    assign avg_clr = (state_q != ST_ACQ);
    assign avg_add = (state_q == ST_ACQ) & adc_valid;

    tempsense_avg u_avg (
`ifdef TEMPSENSE_AVG_EN
        .clk_i   (HF_CLK),
        .rst_n_i (NRST_sync),
`endif
        .clr_i   (avg_clr),
        .add_i   (avg_add),
        .data_i  (adc_data),
        .last_o  (avg_last),
        .mean_o  (avg_mean)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        disc_d   = '0;
        tmo_d    = '0;
        done_d   = done_q;
        err_d    = err_q;
        data_d   = data_q;
        if (!temp_run) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = RUN_ENTRY;
                ST_SETTLE: begin
                    settle_d = settle_q + SW'(1);
                    if (settle_q == SETTLE_LAST) state_d = POST_SETTLE;
                end
                ST_DISCARD: begin
                    tmo_d  = tmo_q + TW'(1);
                    disc_d = disc_q;
                    if (adc_valid) begin
                        disc_d = disc_q + DW'(1);
                        if (disc_q == DISC_LAST) state_d = ST_ACQ;
                    end
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
                ST_ACQ: begin
                    tmo_d = tmo_q + TW'(1);
                    if (avg_last) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        data_d  = avg_mean;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
                ST_HOLD: state_d = ST_HOLD;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HF_CLK or negedge NRST_sync) begin
        if (!NRST_sync) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            disc_q   <= '0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            disc_q   <= disc_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    assign DONE      = done_q;
    assign TEMP_DATA = data_q;
    assign TEMP_ERR  = err_q;

endmodule

// File: doc/tempsense_readout.md
TEMPSENSE_READOUT -- requirements
Module: tempsense_readout

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 64: HF_CLK cycles waited after temp_run rises before any sample is considered.
REQ-002 SHALL have parameter DISCARD_SAMPLES, default 2: adc_valid strobes dropped after settling.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent in DISCARD plus ACQ before aborting with an error.
REQ-004 SHALL have port HF_CLK, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port NRST_sync, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port temp_run, input, 1: conversion window from the controller, level, HF_CLK domain.
REQ-007 SHALL have port adc_valid, input, 1: one-cycle strobe, adc_data valid.
REQ-008 SHALL have port adc_data, input, 12: ADC conversion code.
REQ-009 SHALL have port DONE, output, 1: result ready, level.
REQ-010 SHALL have port TEMP_DATA, output, 12: last completed result.
REQ-011 SHALL have port TEMP_ERR, output, 1: last window ended by timeout.

Function
REQ-012 SHALL implement states IDLE, SETTLE, DISCARD, ACQ, HOLD.
REQ-013 SHALL go IDLE->SETTLE on the first cycle temp_run is sampled high; the settle counter is cleared on entry.
REQ-014 SHALL go SETTLE->DISCARD after exactly SETTLE_CYCLES cycles in SETTLE; SETTLE_CYCLES=0 goes straight to DISCARD.
REQ-015 SHALL count adc_valid strobes in DISCARD and go to ACQ after DISCARD_SAMPLES strobes; DISCARD_SAMPLES=0 skips DISCARD.
REQ-016 SHALL, in ACQ, add adc_data zero-extended into a 15-bit accumulator on each adc_valid; the accumulator is cleared on ACQ entry.
REQ-017 SHALL, on the edge that accepts the final ACQ sample, load TEMP_DATA and set DONE=1, TEMP_ERR=0, and go to HOLD, so DONE appears one cycle after that adc_valid.
REQ-018 SHALL hold DONE=1 and TEMP_DATA stable in HOLD while temp_run stays high; this tolerates the controller's two-stage DONE synchroniser latency.
REQ-019 SHALL ignore adc_valid in IDLE, SETTLE and HOLD.
REQ-020 SHALL, when temp_run is low in any state, go to IDLE on the next edge and clear DONE; TEMP_DATA and TEMP_ERR are retained.
REQ-021 SHALL give temp_run low priority over a coincident final adc_valid: abort, no TEMP_DATA update, DONE stays 0.
REQ-022 SHALL, when the DISCARD+ACQ cycle count reaches TIMEOUT_CYCLES, set TEMP_ERR=1 and DONE=1, leave TEMP_DATA unchanged, and go to HOLD.
REQ-023 SHALL treat temp_run re-rising after IDLE as a fresh window with all counters cleared.
REQ-024 SHALL saturate no counter silently; all counters are sized from their parameters via clog2.

Reset
REQ-025 SHALL, on NRST_sync low, asynchronously force state=IDLE, DONE=0, TEMP_DATA=0, TEMP_ERR=0, and all counters and the accumulator to 0.
REQ-026 SHALL, when reset is released mid-window with temp_run high, start from SETTLE on the first edge.

Configuration
REQ-027 SHALL use macro TEMPSENSE_AVG_EN: when defined, ACQ accepts 8 samples and TEMP_DATA = accumulator[14:3], truncating.
REQ-028 SHALL, without TEMPSENSE_AVG_EN, accept 1 sample in ACQ with TEMP_DATA = adc_data, and omit the accumulator (no accumulator flops).

Structure
REQ-029 SHALL place the state enum, ADC_W=12, AVG_LOG2=3 and ACC_W=ADC_W+AVG_LOG2 in shared package tempsense_pkg.
REQ-030 SHALL place the accumulator and sample counter in sub-module tempsense_avg (clear, add strobe, last flag, mean output); this is the only block affected by TEMPSENSE_AVG_EN.

Verification
REQ-031 SHALL pass: AVG_EN, defaults, temp_run high, 2 discard strobes then 8 strobes of 0x100..0x107 -> DONE one cycle after the 8th, TEMP_DATA=0x103, TEMP_ERR=0.
REQ-032 SHALL pass: adc_valid pulses during the 64 settle cycles and in HOLD -> ignored; the result equals the no-pulse run.
REQ-033 SHALL pass: temp_run drops coincident with the 8th strobe -> DONE stays 0, TEMP_DATA keeps its previous 0x103, state IDLE next cycle.
REQ-034 SHALL pass: no adc_valid for 4096 cycles after settling -> DONE=1, TEMP_ERR=1, TEMP_DATA unchanged; temp_run low -> DONE=0 next cycle.
REQ-035 SHALL pass: NRST_sync pulsed low mid-ACQ -> outputs 0 immediately; with temp_run still high, a full conversion completes normally.
REQ-036 SHALL pass: AVG_EN undefined, single strobe 0xABC after discard -> TEMP_DATA=0xABC, DONE the next cycle.
